rs_err_corrector: RTL and testbench

- Final stage of the RS decoder. It buffers one received codeword, then captures the error positions produced by Chien search together with the error magnitudes from the Forney stage.
- It streams the codeword back out with the magnitudes XORed into the erroneous symbols.
- It is the consumer of the error_positions / error_positions_vld / rs_chien_err interface.

---
 rtl/rs_err_corrector.sv | 151 +++++++++++++++
 tb/tb_rs_err_corrector.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_err_corrector.sv
// RS decoder output stage: buffers one received codeword, captures the Chien/Forney
// error set and streams the codeword back out with the error magnitudes applied.
module rs_err_corrector #(
  parameter int unsigned SYMB_WIDTH = 8,
  parameter int unsigned T_LEN      = 8,
  parameter int unsigned N_LEN      = 255
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [SYMB_WIDTH-1:0]               s_symb,
  input  logic                                s_vld,
  input  logic                                s_last,
  output logic                                s_rdy,
  input  logic [T_LEN-1:0][SYMB_WIDTH-1:0]    error_positions,
  input  logic [T_LEN-1:0][SYMB_WIDTH-1:0]    error_values,
  input  logic                                error_vld,
  input  logic                                rs_chien_err,
  output logic                                error_rdy,
  output logic [SYMB_WIDTH-1:0]               m_symb,
  output logic                                m_vld,
  output logic                                m_last,
  output logic                                m_fail,
  input  logic                                m_rdy
);

  localparam int unsigned CntW  = $clog2(N_LEN + 1);
  localparam int unsigned AddrW = (N_LEN > 1) ? $clog2(N_LEN) : 1;
  localparam logic [CntW-1:0] NLen    = CntW'(N_LEN);
  localparam logic [CntW-1:0] LastIdx = CntW'(N_LEN - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  state_e                           state_q;
  logic [CntW-1:0]                  wr_cnt_q, rd_cnt_q, rd_idx_q;
  logic                             len_err_q, set_held_q, chien_err_q, rd_vld_q;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] pos_q, val_q;
  logic [SYMB_WIDTH-1:0]            mem [N_LEN];
  logic [SYMB_WIDTH-1:0]            rd_data_q;
  logic [1:0][SYMB_WIDTH-1:0]       fifo_symb_q;
  logic [1:0]                       fifo_last_q, fifo_fail_q;
  logic                             fifo_wp_q, fifo_rp_q;
  logic [1:0]                       fifo_cnt_q;

  logic                  s_xfer, e_xfer, load_done, pop, blk_done, rd_en, fail;
  logic [2:0]            occ;
  logic [SYMB_WIDTH-1:0] deg, mask;

  assign s_rdy     = (state_q == StLoad) && (wr_cnt_q < NLen);
  assign error_rdy = (state_q == StLoad) && !set_held_q;
  assign s_xfer    = s_vld && s_rdy;
  assign e_xfer    = error_vld && error_rdy;
  assign load_done = (wr_cnt_q == NLen);

  assign m_vld    = (fifo_cnt_q != 2'd0);
  assign m_symb   = fifo_symb_q[fifo_rp_q];
  assign m_last   = fifo_last_q[fifo_rp_q];
  assign m_fail   = fifo_fail_q[fifo_rp_q];
  assign pop      = m_vld && m_rdy;
  assign blk_done = pop && m_last;
  assign fail     = chien_err_q | len_err_q;

  // Occupancy the skid will have once the in-flight read lands; a new read only
  // issues if it is guaranteed a slot, so backpressure never drops a symbol.
  assign occ   = 3'(fifo_cnt_q) + 3'(rd_vld_q) - 3'(pop);
  assign rd_en = (state_q == StDrain) && (rd_cnt_q < NLen) && (occ < 3'd2);

  // Duplicate positions XOR together; out-of-range positions never equal a degree.
  always_comb begin
    deg  = SYMB_WIDTH'(LastIdx - rd_idx_q);
    mask = '0;
    for (int i = 0; i < T_LEN; i++) begin
      if (pos_q[i] == deg) mask = mask ^ val_q[i];
    end
  end

  always_ff @(posedge aclk) begin
    if (s_xfer) mem[wr_cnt_q[AddrW-1:0]] <= s_symb;
    if (rd_en)  rd_data_q <= mem[rd_cnt_q[AddrW-1:0]];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_idx_q    <= '0;
      rd_vld_q    <= 1'b0;
      len_err_q   <= 1'b0;
      set_held_q  <= 1'b0;
      chien_err_q <= 1'b0;
      pos_q       <= '0;
      val_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle:  state_q <= StLoad;
        StLoad:  if (load_done && set_held_q) state_q <= StDrain;
        StDrain: if (blk_done) state_q <= StLoad;
        default: state_q <= StIdle;
      endcase

      if (s_xfer) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (s_last != (wr_cnt_q == LastIdx)) len_err_q <= 1'b1;
      end

      if (e_xfer) begin
        set_held_q  <= 1'b1;
        pos_q       <= error_positions;
        val_q       <= error_values;
        chien_err_q <= rs_chien_err;
      end

      rd_vld_q <= rd_en;
      if (rd_en) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
        rd_idx_q <= rd_cnt_q;
      end

      if (blk_done) begin
        wr_cnt_q    <= '0;
        rd_cnt_q    <= '0;
        len_err_q   <= 1'b0;
        set_held_q  <= 1'b0;
        chien_err_q <= 1'b0;
        pos_q       <= '0;
        val_q       <= '0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_symb_q <= '0;
      fifo_last_q <= '0;
      fifo_fail_q <= '0;
      fifo_wp_q   <= 1'b0;
      fifo_rp_q   <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      if (rd_vld_q) begin
        fifo_symb_q[fifo_wp_q] <= fail ? rd_data_q : (rd_data_q ^ mask);
        fifo_last_q[fifo_wp_q] <= (rd_idx_q == LastIdx);
        fifo_fail_q[fifo_wp_q] <= fail;
        fifo_wp_q              <= ~fifo_wp_q;
      end
      if (pop) fifo_rp_q <= ~fifo_rp_q;
      fifo_cnt_q <= fifo_cnt_q + 2'(rd_vld_q) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_rs_err_corrector.sv
// Randomized bench for rs_err_corrector: each block's expected output stream is
// derived from a per-degree correction model and compared beat by beat.
module tb_rs_err_corrector;

  localparam int W = 8;
  localparam int T = 8;
  localparam int N = 255;

  logic                 aclk, aresetn;
  logic [W-1:0]         s_symb;
  logic                 s_vld, s_last, s_rdy;
  logic [T-1:0][W-1:0]  error_positions, error_values;
  logic                 error_vld, rs_chien_err, error_rdy;
  logic [W-1:0]         m_symb;
  logic                 m_vld, m_last, m_fail, m_rdy;

  rs_err_corrector #(.SYMB_WIDTH(W), .T_LEN(T), .N_LEN(N)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_symb          (s_symb),
    .s_vld           (s_vld),
    .s_last          (s_last),
    .s_rdy           (s_rdy),
    .error_positions (error_positions),
    .error_values    (error_values),
    .error_vld       (error_vld),
    .rs_chien_err    (rs_chien_err),
    .error_rdy       (error_rdy),
    .m_symb          (m_symb),
    .m_vld           (m_vld),
    .m_last          (m_last),
    .m_fail          (m_fail),
    .m_rdy           (m_rdy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Block description and reference results.
  logic [W-1:0] blk   [N];
  int           epos  [T];
  logic [W-1:0] evals [T];
  bit           chien;
  int           slast_at;
  logic [W-1:0] exp_s [N];
  bit           exp_f;
  int           t_last, t_set;

  function automatic void model();
    exp_f = chien || (slast_at != N - 1);
    for (int j = 0; j < N; j++) begin
      logic [W-1:0] corr;
      corr = '0;
      for (int i = 0; i < T; i++)
        if (epos[i] == N - 1 - j) corr = corr ^ evals[i];
      exp_s[j] = exp_f ? blk[j] : blk[j] ^ corr;
    end
  endfunction

  task automatic run_block(input int rdy_pct, input int sym_delay, input int set_delay,
                           input int abort_beat);
    model();
    t_last = -1;
    t_set  = -1;
    fork
      begin : producer
        int guard;
        repeat (sym_delay) @(negedge aclk);
        for (int j = 0; j < N; j++) begin
          s_symb = blk[j];
          s_vld  = 1'b1;
          s_last = (j == slast_at);
          guard  = 0;
          while (!s_rdy && guard < 2000) begin
            @(negedge aclk);
            guard++;
          end
          if (guard >= 2000) begin
            check_eq("s_rdy_timeout", 32'(s_rdy), 32'd1);
            break;
          end
          if (j == N - 1) t_last = cyc;
          @(negedge aclk);
        end
        s_vld  = 1'b0;
        s_last = 1'b0;
      end
      begin : err_set
        int guard;
        repeat (set_delay) @(negedge aclk);
        for (int i = 0; i < T; i++) begin
          error_positions[i] = W'(epos[i]);
          error_values[i]    = evals[i];
        end
        rs_chien_err = chien;
        error_vld    = 1'b1;
        guard        = 0;
        while (!error_rdy && guard < 2000) begin
          @(negedge aclk);
          guard++;
        end
        check_eq("error_rdy_wait", 32'(error_rdy), 32'd1);
        t_set = cyc;
        @(negedge aclk);
        error_vld    = 1'b0;
        rs_chien_err = 1'b0;
        check_eq("error_rdy_drops", 32'(error_rdy), 32'd0);
      end
      begin : consumer
        int  beat, guard;
        bit  first, aborted;
        beat = 0; guard = 0; first = 1; aborted = 0;
        while (beat < N && guard < 5000 && !aborted) begin
          m_rdy = ($urandom_range(99) < rdy_pct);
          if (m_vld) begin
            if (first) begin
              check_eq("first_vld_latency", 32'(cyc),
                       32'(((t_last > t_set) ? t_last : t_set) + 4));
              check_eq("s_rdy_in_drain", 32'(s_rdy), 32'd0);
              check_eq("error_rdy_in_drain", 32'(error_rdy), 32'd0);
              first = 0;
            end
            if (beat == abort_beat) begin
              aresetn = 1'b0;
              #1;
              check_eq("abort_m_vld", 32'(m_vld), 32'd0);
              check_eq("abort_m_symb", 32'(m_symb), 32'd0);
              check_eq("abort_s_rdy", 32'(s_rdy), 32'd0);
              check_eq("abort_error_rdy", 32'(error_rdy), 32'd0);
              m_rdy = 1'b0;
              @(negedge aclk);
              aresetn = 1'b1;
              aborted = 1;
            end else begin
              check_eq($sformatf("symb[%0d]", beat), 32'(m_symb), 32'(exp_s[beat]));
              check_eq($sformatf("last[%0d]", beat), 32'(m_last), 32'(beat == N - 1));
              check_eq($sformatf("fail[%0d]", beat), 32'(m_fail), 32'(exp_f));
              if (m_rdy) beat++;
            end
          end
          if (!aborted) begin
            @(negedge aclk);
            guard++;
          end
        end
        if (!aborted) begin
          check_eq("drain_complete", 32'(beat), 32'(N));
          check_eq("s_rdy_after_last", 32'(s_rdy), 32'd1);
          check_eq("error_rdy_after_last", 32'(error_rdy), 32'd1);
          check_eq("m_vld_after_last", 32'(m_vld), 32'd0);
        end
        m_rdy = 1'b0;
      end
    join
  endtask

  task automatic rand_block();
    for (int j = 0; j < N; j++) blk[j] = W'($urandom);
    for (int i = 0; i < T; i++) begin
      epos[i]  = 0;
      evals[i] = '0;
    end
    chien    = 0;
    slast_at = N - 1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    aresetn = 1'b1;
    s_symb = '0; s_vld = 1'b0; s_last = 1'b0;
    error_positions = '0; error_values = '0; error_vld = 1'b0; rs_chien_err = 1'b0;
    m_rdy = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    check_eq("rst_s_rdy", 32'(s_rdy), 32'd0);
    check_eq("rst_error_rdy", 32'(error_rdy), 32'd0);
    check_eq("rst_m_vld", 32'(m_vld), 32'd0);
    check_eq("rst_m_last", 32'(m_last), 32'd0);
    check_eq("rst_m_fail", 32'(m_fail), 32'd0);
    check_eq("rst_m_symb", 32'(m_symb), 32'd0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    // No errors, ramp data.
    rand_block();
    for (int j = 0; j < N; j++) blk[j] = W'(j);
    run_block(100, 0, 2, -1);

    // Errors at both ends, plus an out-of-range position that must be ignored.
    rand_block();
    epos[0] = 254; evals[0] = 8'h5A;
    epos[1] = 0;   evals[1] = 8'h01;
    epos[2] = 255; evals[2] = 8'h33;
    run_block(100, 0, 0, -1);

    // Full set with a duplicate position at degree 10.
    rand_block();
    epos[0] = 10; evals[0] = 8'h0F;
    epos[1] = 10; evals[1] = 8'hF0;
    for (int i = 2; i < T; i++) begin
      epos[i]  = 11 + (i - 2) * 40 + int'($urandom_range(0, 30));
      evals[i] = W'($urandom_range(1, 255));
    end
    run_block(100, 0, 300, -1);

    // Decode failure: raw data must come out.
    rand_block();
    for (int i = 0; i < T; i++) begin
      epos[i]  = int'($urandom_range(0, N - 1));
      evals[i] = W'($urandom_range(1, 255));
    end
    chien = 1;
    run_block(100, 0, 5, -1);

    // Misplaced s_last: still N symbols taken, block flagged.
    rand_block();
    for (int i = 0; i < T; i++) begin
      epos[i]  = int'($urandom_range(0, N - 1));
      evals[i] = W'($urandom_range(1, 255));
    end
    slast_at = 100;
    run_block(100, 0, 1, -1);

    // Error set ahead of the data and random backpressure.
    rand_block();
    for (int i = 0; i < T; i++) begin
      epos[i]  = int'($urandom_range(0, N - 1));
      evals[i] = W'($urandom_range(0, 255));
    end
    run_block(50, 5, 0, -1);

    // Reset during drain, then a fresh block with random backpressure.
    rand_block();
    for (int i = 0; i < T; i++) begin
      epos[i]  = int'($urandom_range(0, N - 1));
      evals[i] = W'($urandom_range(1, 255));
    end
    run_block(100, 0, 0, 50);
    rand_block();
    epos[0] = int'($urandom_range(0, N - 1));
    evals[0] = W'($urandom_range(1, 255));
    run_block(50, 0, 3, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
